// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4 arbiter.
// Downstream ID width is derived here so every file agrees on it.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One extra ID bit carries the grant index downstream.
    function automatic int unsigned m_id_w(input int unsigned id_w);
        return id_w + 1;
    endfunction

endpackage

// File: rtl/axi_arb_rr.sv
// Two-way arbiter; round-robin by default, fixed priority (master 0)
// when AXI_ARB_QOS_EN is defined.
module axi_arb_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant
);

`ifdef AXI_ARB_QOS_EN

    always_comb begin
        grant = ~req[0];
    end

`else

    logic last_q;
    logic last_d;

    // Pointer holds the previous winner; resets to 1 so master 0 wins first.
    always_comb begin
        grant  = (req == 2'b11) ? ~last_q : req[1];
        last_d = last_q;
        if (grant_en && (req != 2'b00)) begin
            last_d = grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule

// File: rtl/axi_m0_arbiter.sv
// Two-to-one AXI4 arbiter with independent read/write FSMs, one burst each.
// Define AXI_ARB_QOS_EN for fixed priority in place of round-robin.
module axi_m0_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int unsigned ADDR_W = 31,
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned ID_W   = 4,
    localparam int unsigned MID_W  = m_id_w(ID_W),
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    // upstream master 0
    input  logic [ID_W-1:0]   s0_awid,
    input  logic [ADDR_W-1:0] s0_awaddr,
    input  logic [7:0]        s0_awlen,
    input  logic [2:0]        s0_awsize,
    input  logic [1:0]        s0_awburst,
    input  logic              s0_awlock,
    input  logic [3:0]        s0_awcache,
    input  logic [2:0]        s0_awprot,
    input  logic              s0_awvalid,
    output logic              s0_awready,
    input  logic [DATA_W-1:0] s0_wdata,
    input  logic [STRB_W-1:0] s0_wstrb,
    input  logic              s0_wlast,
    input  logic              s0_wvalid,
    output logic              s0_wready,
    output logic [ID_W-1:0]   s0_bid,
    output logic [1:0]        s0_bresp,
    output logic              s0_bvalid,
    input  logic              s0_bready,
    input  logic [ID_W-1:0]   s0_arid,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic [7:0]        s0_arlen,
    input  logic [2:0]        s0_arsize,
    input  logic [1:0]        s0_arburst,
    input  logic              s0_arlock,
    input  logic [3:0]        s0_arcache,
    input  logic [2:0]        s0_arprot,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [ID_W-1:0]   s0_rid,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rlast,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    // upstream master 1
    input  logic [ID_W-1:0]   s1_awid,
    input  logic [ADDR_W-1:0] s1_awaddr,
    input  logic [7:0]        s1_awlen,
    input  logic [2:0]        s1_awsize,
    input  logic [1:0]        s1_awburst,
    input  logic              s1_awlock,
    input  logic [3:0]        s1_awcache,
    input  logic [2:0]        s1_awprot,
    input  logic              s1_awvalid,
    output logic              s1_awready,
    input  logic [DATA_W-1:0] s1_wdata,
    input  logic [STRB_W-1:0] s1_wstrb,
    input  logic              s1_wlast,
    input  logic              s1_wvalid,
    output logic              s1_wready,
    output logic [ID_W-1:0]   s1_bid,
    output logic [1:0]        s1_bresp,
    output logic              s1_bvalid,
    input  logic              s1_bready,
    input  logic [ID_W-1:0]   s1_arid,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic [7:0]        s1_arlen,
    input  logic [2:0]        s1_arsize,
    input  logic [1:0]        s1_arburst,
    input  logic              s1_arlock,
    input  logic [3:0]        s1_arcache,
    input  logic [2:0]        s1_arprot,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [ID_W-1:0]   s1_rid,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rlast,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    // downstream master
    output logic [MID_W-1:0]  m_awid,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_awlock,
    output logic [3:0]        m_awcache,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [MID_W-1:0]  m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [MID_W-1:0]  m_arid,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arlock,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [MID_W-1:0]  m_rid,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready
);

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic     w_gnt_q, w_gnt_d;
    logic     r_gnt_q, r_gnt_d;
    logic     aw_done_q, aw_done_d;
    logic     w_done_q, w_done_d;
    logic     w_arb_gnt, r_arb_gnt;
    logic     unused_id_msb;

    // Routing uses the registered grant; the returned ID MSB is ignored.
    assign unused_id_msb = m_bid[ID_W] ^ m_rid[ID_W];

    axi_arb_rr u_w_arb (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .req      ({s1_awvalid, s0_awvalid}),
        .grant_en (w_state_q == W_IDLE),
        .grant    (w_arb_gnt)
    );

    axi_arb_rr u_r_arb (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .req      ({s1_arvalid, s0_arvalid}),
        .grant_en (r_state_q == R_IDLE),
        .grant    (r_arb_gnt)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_gnt_q   <= 1'b0;
            r_gnt_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_gnt_q   <= w_gnt_d;
            r_gnt_q   <= r_gnt_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_gnt_d   = w_gnt_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (w_state_q)
            W_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (s0_awvalid || s1_awvalid) begin
                    w_gnt_d   = w_arb_gnt;
                    w_state_d = W_XFER;
                end
            end
            W_XFER: begin
                // AW and the last W beat may complete in either order or together.
                aw_done_d = aw_done_q | (m_awvalid & m_awready);
                w_done_d  = w_done_q | (m_wvalid & m_wready & m_wlast);
                if (aw_done_d && w_done_d) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (m_bvalid && m_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        r_gnt_d   = r_gnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (s0_arvalid || s1_arvalid) begin
                    r_gnt_d   = r_arb_gnt;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (m_arvalid && m_arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (m_rvalid && m_rready && m_rlast) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        m_awid    = '0;
        m_awaddr  = '0;
        m_awlen   = '0;
        m_awsize  = '0;
        m_awburst = '0;
        m_awlock  = 1'b0;
        m_awcache = '0;
        m_awprot  = '0;
        m_awvalid = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        s0_bid     = '0;
        s1_bid     = '0;
        s0_bresp   = '0;
        s1_bresp   = '0;
        s0_bvalid  = 1'b0;
        s1_bvalid  = 1'b0;
        case (w_state_q)
            W_XFER: begin
                m_awid    = {w_gnt_q, (w_gnt_q ? s1_awid : s0_awid)};
                m_awaddr  = w_gnt_q ? s1_awaddr  : s0_awaddr;
                m_awlen   = w_gnt_q ? s1_awlen   : s0_awlen;
                m_awsize  = w_gnt_q ? s1_awsize  : s0_awsize;
                m_awburst = w_gnt_q ? s1_awburst : s0_awburst;
                m_awlock  = w_gnt_q ? s1_awlock  : s0_awlock;
                m_awcache = w_gnt_q ? s1_awcache : s0_awcache;
                m_awprot  = w_gnt_q ? s1_awprot  : s0_awprot;
                m_awvalid = (w_gnt_q ? s1_awvalid : s0_awvalid) & ~aw_done_q;
                m_wdata   = w_gnt_q ? s1_wdata : s0_wdata;
                m_wstrb   = w_gnt_q ? s1_wstrb : s0_wstrb;
                m_wlast   = w_gnt_q ? s1_wlast : s0_wlast;
                m_wvalid  = (w_gnt_q ? s1_wvalid : s0_wvalid) & ~w_done_q;
                if (w_gnt_q) begin
                    s1_awready = m_awready & ~aw_done_q;
                    s1_wready  = m_wready & ~w_done_q;
                end else begin
                    s0_awready = m_awready & ~aw_done_q;
                    s0_wready  = m_wready & ~w_done_q;
                end
            end
            W_RESP: begin
                m_bready = w_gnt_q ? s1_bready : s0_bready;
                if (w_gnt_q) begin
                    s1_bvalid = m_bvalid;
                    s1_bid    = m_bid[ID_W-1:0];
                    s1_bresp  = m_bresp;
                end else begin
                    s0_bvalid = m_bvalid;
                    s0_bid    = m_bid[ID_W-1:0];
                    s0_bresp  = m_bresp;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        m_arsize  = '0;
        m_arburst = '0;
        m_arlock  = 1'b0;
        m_arcache = '0;
        m_arprot  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rid     = '0;
        s1_rid     = '0;
        s0_rdata   = '0;
        s1_rdata   = '0;
        s0_rresp   = '0;
        s1_rresp   = '0;
        s0_rlast   = 1'b0;
        s1_rlast   = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        case (r_state_q)
            R_ADDR: begin
                m_arid    = {r_gnt_q, (r_gnt_q ? s1_arid : s0_arid)};
                m_araddr  = r_gnt_q ? s1_araddr  : s0_araddr;
                m_arlen   = r_gnt_q ? s1_arlen   : s0_arlen;
                m_arsize  = r_gnt_q ? s1_arsize  : s0_arsize;
                m_arburst = r_gnt_q ? s1_arburst : s0_arburst;
                m_arlock  = r_gnt_q ? s1_arlock  : s0_arlock;
                m_arcache = r_gnt_q ? s1_arcache : s0_arcache;
                m_arprot  = r_gnt_q ? s1_arprot  : s0_arprot;
                m_arvalid = r_gnt_q ? s1_arvalid : s0_arvalid;
                if (r_gnt_q) begin
                    s1_arready = m_arready;
                end else begin
                    s0_arready = m_arready;
                end
            end
            R_DATA: begin
                m_rready = r_gnt_q ? s1_rready : s0_rready;
                if (r_gnt_q) begin
                    s1_rvalid = m_rvalid;
                    s1_rid    = m_rid[ID_W-1:0];
                    s1_rdata  = m_rdata;
                    s1_rresp  = m_rresp;
                    s1_rlast  = m_rlast;
                end else begin
                    s0_rvalid = m_rvalid;
                    s0_rid    = m_rid[ID_W-1:0];
                    s0_rdata  = m_rdata;
                    s0_rresp  = m_rresp;
                    s0_rlast  = m_rlast;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/axi_m0_arbiter.md
# axi_m0_arbiter

Two-to-one AXI4 arbiter that shares the Nios V system's single downstream AXI4 bridge master (31-bit address, 32-bit data, 5-bit ID) between two upstream AXI4 masters. Read and write directions are arbitrated independently, with one outstanding burst per direction. The block sits between the requesters (CPU-side bridge, DMA) and the fabric port that drives external memory/peripherals. ID bit 4 on the downstream side carries the grant index.

## Interface
Parameters:
- ADDR_W, 31, address width, all sides
- DATA_W, 32, data width; strobe width DATA_W/8
- ID_W, 4, upstream ID width; downstream ID width is ID_W+1

Ports:
- clk_clk  in  1  single clock for all logic
- reset_reset_n  in  1  asynchronous, active-low reset
- sN_aw{id,addr,len,size,burst,lock,cache,prot,valid} / sN_awready (N=0,1)  in/out  ID_W,ADDR_W,8,3,2,1,4,3,1 / 1  upstream write address
- sN_w{data,strb,last,valid} / sN_wready  in/out  DATA_W,DATA_W/8,1,1 / 1  upstream write data
- sN_b{id,resp,valid} / sN_bready  out/in  ID_W,2,1 / 1  upstream write response
- sN_ar{id,addr,len,size,burst,lock,cache,prot,valid} / sN_arready  in/out  as AW  upstream read address
- sN_r{id,data,resp,last,valid} / sN_rready  out/in  ID_W,DATA_W,2,1,1 / 1  upstream read data
- m_aw*, m_w*, m_b*, m_ar*, m_r*  mirrored  ID fields ID_W+1, else as upstream  downstream AXI4 master

## Operation
- Write FSM: W_IDLE -> W_XFER -> W_RESP -> W_IDLE. Read FSM: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
- IDLE: if any sN_awvalid (resp. arvalid), register grant index and enter W_XFER (R_ADDR). No upstream ready is asserted in IDLE.
- Arbitration: round-robin. last_w/last_r pointer records the previous winner. When both request, the one not equal to the pointer wins. When one requests, it wins. The pointer updates at grant. Pointer reset value 1, so master 0 wins the first contest.
- W_XFER: AW and W are forwarded from the granted master. m_awvalid = sG_awvalid while aw_done=0. m_awid = {G, sG_awid}. W is forwarded while w_done=0, and may complete before AW (AXI-legal). aw_done sets on AW handshake. w_done sets on the handshake with wlast=1. Enter W_RESP when both are set, including both in the same cycle.
- W_RESP: route m_b* to sG. sG_bid = m_bid[ID_W-1:0]. m_bready = sG_bready. Routing uses the registered G; m_bid[ID_W] is not used for routing. Return to W_IDLE on the B handshake.
- R_ADDR: forward AR with m_arid = {G, sG_arid}. Enter R_DATA on the AR handshake.
- R_DATA: route m_r* to sG. Return to R_IDLE on the R handshake with rlast=1.
- Non-granted master: all readys/valids to it are held at 0. All downstream valids are 0 outside their active state.
- Reset mid-burst: both FSMs go to IDLE, flags clear, pointers go to 1. Partial bursts are abandoned; the system reset recovers the fabric.
- Reset values: every m_*valid, m_bready, m_rready, sN_*ready and sN_*valid is 0. Data/ID outputs are don't-care but driven 0 in IDLE.

## Timing
- Grant latency: upstream valid sampled in IDLE -> downstream valid asserted in the next cycle.
- Within an active state, ready/valid/data are combinational pass-throughs with no skid buffer, so there is zero added latency per beat.
- Turnaround: the final B or R handshake is followed by one IDLE cycle, then the next grant's ADDR cycle. The minimum gap between bursts in the same direction is 2 cycles.
- Reads and writes proceed concurrently and independently.

## Configuration
- AXI_ARB_QOS_EN defined: fixed priority, where master 0 always wins a simultaneous request and pointers are unused (optimised away).
- Undefined: round-robin as above.

## Structure
- Package axi_arb_pkg: write/read state enums, AXI burst/resp constants, and the downstream ID-width derivation.
- Sub-module axi_arb_rr: 2-way arbiter (req[1:0], grant_en -> grant, pointer register). It contains the AXI_ARB_QOS_EN switch and is instantiated once per direction.

## Test plan
- Single write, s0 AW addr 0x0000_1000 len 3 with 4 W beats -> m_awid 0x0_? with bit4=0, 4 beats forwarded, bresp OKAY returned only to s0, s1 sees no bvalid.
- Simultaneous s0/s1 reads (len 0) issued repeatedly 4 times -> grants alternate 0,1,0,1, and each burst's m_arid[4] matches its grant (with QOS_EN, all four grants go to 0 while s0 keeps requesting).
- W data before AW: s1 wvalid+wlast asserted 3 cycles before awvalid, m_awready held low -> W handshake completes first, W_RESP is entered only after the AW handshake.
- Concurrent s0 write and s1 read bursts of len 7 -> both complete with no interleaving stalls, rdata ordering is preserved, and the gap to the next s0 write is 2 cycles.
- Backpressure: sG_rready toggled every other cycle during an 8-beat read -> m_rready mirrors it and no beat is lost or duplicated.
- reset_reset_n pulsed low mid-read at beat 3 -> all valids/readys are 0 asynchronously, and after release the first simultaneous request is granted to s0.
